// File: rtl/core_pkg.sv
// Shared types and constants for the core
// fetch/execute sequencer.
package core_pkg;

  localparam int PC_W_D    = 15;
  localparam int INSTR_W_D = 16;
  localparam int TMO_W     = 8;

  localparam logic [INSTR_W_D-1:0] NOP = '0;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_RUN,
    ST_DRAIN,
    ST_PAUSED,
    ST_STEP,
    ST_HALTED
  } state_e;

endpackage

// File: rtl/core_seq_if.sv
// Instruction-fetch valid/ready bus between
// the sequencer (master) and memory (slave).
interface core_seq_if
  import core_pkg::*;
#(
  parameter int PC_W    = PC_W_D,
  parameter int INSTR_W = INSTR_W_D
);

  logic               fetch_req;
  logic [PC_W-1:0]    fetch_addr;
  logic               mem_ready;
  logic [INSTR_W-1:0] mem_rdata;

  modport master (
    output fetch_req,
    output fetch_addr,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  fetch_req,
    input  fetch_addr,
    output mem_ready,
    output mem_rdata
  );

endinterface

// File: rtl/core_seq_tmo.sv
// Fetch wait-state counter; flags the wait
// cycle on which the limit is reached.
module core_seq_tmo
  import core_pkg::*;
#(
  parameter int TMO_CYC = 15
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req,
  input  logic i_ready,
  output logic o_hit
);

  localparam logic [TMO_W-1:0] LIM =
    TMO_W'(TMO_CYC - 1);

  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W-1:0] cnt_d;
  logic             wait_c;

  assign wait_c = i_req & ~i_ready;
  assign o_hit  = wait_c & (cnt_q == LIM);

  // count stalled request cycles, clear otherwise
  always_comb begin
    cnt_d = '0;
    if (wait_c && !o_hit) begin
      cnt_d = cnt_q + TMO_W'(1);
    end
  end

  // counter register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/core_seq.sv
// Fetch/execute sequencer: owns PC, EXECUTE
// register, run/pause/step/halt control.
module core_seq
  import core_pkg::*;
#(
  parameter int PC_W    = PC_W_D,
  parameter int INSTR_W = INSTR_W_D,
  parameter int TMO_CYC = 15
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_booted,
  input  logic               i_start_pause,
  input  logic               i_step,
  output logic               o_now_paused,
  core_seq_if.master         fetch,
  output logic [INSTR_W-1:0] o_exe_instr,
  output logic               o_exe_valid,
  output logic [PC_W-1:0]    o_exe_pc,
  input  logic               i_exe_busy,
  input  logic               i_exe_halt,
  input  logic               i_jmp_take,
  input  logic [PC_W-1:0]    i_jmp_addr,
  output logic [PC_W-1:0]    o_report_pc,
  output logic               o_report_hlt,
  output logic               o_fetch_err
);

  localparam logic [INSTR_W-1:0] NOPW =
    INSTR_W'(NOP);

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    epc_q, epc_d;
  logic [INSTR_W-1:0] exe_q, exe_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;

  logic            jmp;
  logic            halt;
  logic            req;
  logic            fire;
  logic            hit;
  logic [PC_W-1:0] pc_inc;

  assign jmp    = i_jmp_take & valid_q;
  assign halt   = valid_q & i_exe_halt;
  assign req    = ((state_q == ST_RUN) |
                   ((state_q == ST_STEP) & ~valid_q)) &
                  ~i_exe_busy & ~halt;
  assign fire   = req & fetch.mem_ready;
  assign pc_inc = pc_q + PC_W'(1);

  core_seq_tmo #(
    .TMO_CYC (TMO_CYC)
  ) u_tmo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_req   (req),
    .i_ready (fetch.mem_ready),
    .o_hit   (hit)
  );

  // next state, PC and EXECUTE selection
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    exe_d   = exe_q;
    valid_d = valid_q;
    err_d   = err_q | hit;
    unique case (state_q)
      ST_BOOT: begin
        if (i_booted) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (jmp) begin
          pc_d    = i_jmp_addr;
          exe_d   = NOPW;
          valid_d = 1'b0;
          if (i_start_pause) state_d = ST_DRAIN;
        end else if (i_exe_busy) begin
          if (i_start_pause) state_d = ST_DRAIN;
        end else if (halt) begin
          state_d = ST_HALTED;
        end else begin
          if (fire) begin
            exe_d   = fetch.mem_rdata;
            valid_d = 1'b1;
            epc_d   = pc_inc;
            pc_d    = pc_inc;
          end else begin
            exe_d   = NOPW;
            valid_d = 1'b0;
          end
          if (i_start_pause) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (jmp) begin
          pc_d    = i_jmp_addr;
          exe_d   = NOPW;
          valid_d = 1'b0;
          state_d = ST_PAUSED;
        end else if (i_exe_busy) begin
          state_d = ST_DRAIN;
        end else if (halt) begin
          state_d = ST_HALTED;
        end else begin
          exe_d   = NOPW;
          valid_d = 1'b0;
          state_d = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        exe_d   = NOPW;
        valid_d = 1'b0;
        if (!i_start_pause) state_d = ST_RUN;
        else if (i_step) state_d = ST_STEP;
      end
      ST_STEP: begin
        if (!valid_q) begin
          if (fire) begin
            exe_d   = fetch.mem_rdata;
            valid_d = 1'b1;
            epc_d   = pc_inc;
            pc_d    = pc_inc;
          end else begin
            exe_d   = NOPW;
          end
        end else if (jmp) begin
          pc_d    = i_jmp_addr;
          exe_d   = NOPW;
          valid_d = 1'b0;
          state_d = ST_PAUSED;
        end else if (i_exe_busy) begin
          state_d = ST_STEP;
        end else if (halt) begin
          state_d = ST_HALTED;
        end else begin
          exe_d   = NOPW;
          valid_d = 1'b0;
          state_d = ST_PAUSED;
        end
      end
      ST_HALTED: begin
        if (i_start_pause) begin
          exe_d   = NOPW;
          valid_d = 1'b0;
          state_d = ST_PAUSED;
        end
      end
      default: state_d = ST_BOOT;
    endcase
    if (hit) begin
      exe_d   = NOPW;
      valid_d = 1'b0;
      state_d = ST_PAUSED;
    end
  end

  // sequencer state registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_BOOT;
      pc_q    <= '0;
      epc_q   <= '0;
      exe_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      exe_q   <= exe_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign fetch.fetch_req  = req;
  assign fetch.fetch_addr = pc_q;
  assign o_now_paused     = (state_q == ST_PAUSED);
  assign o_report_hlt     = (state_q == ST_HALTED);
  assign o_report_pc      = pc_q;
  assign o_exe_instr      = exe_q;
  assign o_exe_valid      = valid_q;
  assign o_exe_pc         = epc_q;
  assign o_fetch_err      = err_q;

endmodule
